// File: rtl/sb_cfg_loader_if.sv
// rtl/sb_cfg_loader_if.sv - byte-serial configuration handshake between controller and loader
interface sb_cfg_loader_if;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_abort;
    logic       cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_abort,
        output cfg_ready
    );
endinterface

// File: rtl/sb_cfg_loader.sv
// rtl/sb_cfg_loader.sv - checksummed frame loader committing atomically onto the switch-box con bus
module sb_cfg_loader #(
    parameter int          CFG_W  = 384,
    parameter logic [7:0]  SYNC   = 8'hA5,
    localparam int         NBYTES = CFG_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sb_cfg_loader_if.slave    cfg,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [CFG_W-1:0]  con
);
    localparam int              CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         xacc_q, xacc_d;
    logic               ok_q, ok_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CFG_W-1:0]   con_q, con_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic               accept;

    // Ready is a pure state decode, held low while reset is asserted.
    assign cfg.cfg_ready = rst_n && (state_q != ST_COMMIT);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_busy      = (state_q != ST_IDLE);
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
    assign con           = con_q;

    // Next-state, byte assembly and commit decisions; abort beats a same-cycle byte.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xacc_d   = xacc_q;
        ok_d     = ok_q;
        con_d    = con_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && cfg.cfg_data == SYNC) begin
                    cnt_d   = '0;
                    xacc_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg.cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    shadow_d[{cnt_q, 3'b000} +: 8] = cfg.cfg_data;
                    xacc_d = xacc_q ^ cfg.cfg_data;
                    if (cnt_q == LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (cfg.cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    ok_d    = (cfg.cfg_data == xacc_q);
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (ok_q) begin
                    con_d  = shadow_q;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and the live configuration; reset clears con so all selects go off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xacc_q  <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            con_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xacc_q  <= xacc_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            err_q   <= err_d;
            con_q   <= con_d;
        end
    end

    // Shadow is pure data storage; its contents only matter once a frame completes.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end
endmodule

// File: tb/tb_sb_cfg_loader.sv
// tb/tb_sb_cfg_loader.sv - directed and randomized self-checking bench for sb_cfg_loader
module tb_sb_cfg_loader;
    localparam int         CFG_W = 384;
    localparam int         NB    = CFG_W / 8;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             busy, done, err;
    logic [CFG_W-1:0] con;

    int passed = 0;
    int total  = 0;

    logic [7:0]       fr [NB];
    logic [CFG_W-1:0] con_model;

    always #5 clk = ~clk;

    sb_cfg_loader_if cfg();

    sb_cfg_loader #(.CFG_W(CFG_W), .SYNC(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg      (cfg),
        .cfg_busy (busy),
        .cfg_done (done),
        .cfg_err  (err),
        .con      (con)
    );

    task automatic check(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NB; k++) x ^= fr[k];
        return x;
    endfunction

    function automatic logic [CFG_W-1:0] frame_image();
        logic [CFG_W-1:0] v = '0;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = fr[k];
        return v;
    endfunction

    // Present one byte after `gap` idle cycles and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            cfg.cfg_valid = 1'b0;
        end
        @(negedge clk);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_data  = b;
        n = 0;
        while (cfg.cfg_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n == 10) check("ready_timeout", {383'b0, cfg.cfg_ready}, 1);
        @(posedge clk);
        #1;
        cfg.cfg_valid = 1'b0;
    endtask

    // Send SYNC + data + checksum, then verify the commit cycle against the model.
    task automatic send_frame(input logic [7:0] chk, input int maxgap, input bit b2b, input string tag);
        bit good;
        send_byte(SYNC, $urandom_range(maxgap, 0));
        for (int k = 0; k < NB; k++) send_byte(fr[k], $urandom_range(maxgap, 0));
        send_byte(chk, $urandom_range(maxgap, 0));
        good = (chk == frame_xor());
        if (b2b) begin
            cfg.cfg_valid = 1'b1;
            cfg.cfg_data  = SYNC;
        end
        check({tag, "_commit_ready"}, {383'b0, cfg.cfg_ready}, 0);
        check({tag, "_commit_busy"}, {383'b0, busy}, 1);
        @(posedge clk);
        #1;
        if (good) con_model = frame_image();
        check({tag, "_done"}, {383'b0, done}, {383'b0, good});
        check({tag, "_err"}, {383'b0, err}, {383'b0, !good});
        check({tag, "_con"}, con, con_model);
        check({tag, "_idle_busy"}, {383'b0, busy}, 0);
        if (!b2b) begin
            @(posedge clk);
            #1;
            check({tag, "_pulse_len"}, {382'b0, done, err}, 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        logic [7:0] x;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_data  = SYNC;
        cfg.cfg_abort = 1'b0;
        rst_n         = 1'b0;
        con_model     = '0;

        // Reset holds everything quiet even with valid asserted.
        repeat (3) @(negedge clk);
        check("rst_con", con, '0);
        check("rst_ready", {383'b0, cfg.cfg_ready}, 0);
        check("rst_flags", {381'b0, busy, done, err}, 0);
        cfg.cfg_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", {383'b0, cfg.cfg_ready}, 1);
        check("rst_release_busy", {383'b0, busy}, 0);

        // Known good frame.
        for (int k = 0; k < NB; k++) fr[k] = 8'h00;
        fr[0] = 8'h21;
        fr[1] = 8'h01;
        send_frame(8'h20, 0, 1'b0, "good");
        check("good_low16", {368'b0, con[15:0]}, {368'b0, 16'h0121});
        check("good_rest", {16'b0, con[CFG_W-1:16]}, '0);

        // Same frame, wrong checksum: con must not move.
        fr[0] = 8'h55;
        send_frame(8'h21 ^ 8'h55 ^ 8'h01, 0, 1'b0, "bad");

        // Abort after 20 data bytes, with a byte presented in the same cycle.
        for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
        send_byte(SYNC, 0);
        for (int k = 0; k < 20; k++) send_byte(fr[k], 0);
        @(negedge clk);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_data  = 8'h3C;
        cfg.cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_abort = 1'b0;
        check("abort_busy", {383'b0, busy}, 0);
        check("abort_con", con, con_model);
        check("abort_flags", {382'b0, done, err}, 0);
        send_frame(frame_xor(), 0, 1'b0, "after_abort");

        // Junk bytes in IDLE are ignored.
        send_byte(8'h00, 0);
        check("junk00_busy", {383'b0, busy}, 0);
        send_byte(8'hFF, 0);
        check("junkff_busy", {383'b0, busy}, 0);
        send_byte(8'h5A, 0);
        check("junk5a_busy", {383'b0, busy}, 0);

        // Stalled frame carrying SYNC as ordinary data.
        for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
        fr[5] = SYNC;
        send_frame(frame_xor(), 3, 1'b0, "stall");

        // Random frames, some with a corrupted checksum.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
            x = frame_xor();
            if (r == 1) x = x ^ 8'($urandom_range(255, 1));
            send_frame(x, 1, 1'b0, "rand");
        end

        // Back-to-back: second SYNC waits out the COMMIT cycle.
        for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
        send_frame(frame_xor(), 0, 1'b1, "b2b1");
        for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
        send_frame(frame_xor(), 0, 1'b0, "b2b2");

        // Reset mid-frame clears con immediately.
        send_byte(SYNC, 0);
        for (int k = 0; k < 10; k++) send_byte(fr[k], 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        con_model = '0;
        check("midrst_con", con, con_model);
        check("midrst_busy", {383'b0, busy}, 0);
        check("midrst_ready", {383'b0, cfg.cfg_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NB; k++) fr[k] = 8'($urandom);
        send_frame(frame_xor(), 2, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sb_cfg_loader.md
# sb_cfg_loader

Configuration writer for the switch box. Accepts a byte-serial configuration frame from the fabric configuration controller and assembles it into a shadow register. After a checksum check, it commits the frame atomically onto the 384-bit `con` bus that drives the switch box's per-pin select fields. A frame with a bad checksum, or an aborted frame, never disturbs the live configuration.

## Interface
Parameters:
- `CFG_W`, 384: width of the switch-box configuration bus; must be a multiple of 8.
- `NBYTES`, `CFG_W/8` (48): data bytes per frame; derived, not overridden.
- `SYNC`, 8'hA5: start-of-frame byte.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_valid`  in  1  `cfg_data` is valid this cycle.
- `cfg_data`  in  8  frame byte.
- `cfg_abort`  in  1  discard the frame in progress and return to IDLE.
- `cfg_ready`  out  1  loader accepts a byte this cycle.
- `cfg_busy`  out  1  high while a frame is in progress (LOAD, CHECK, COMMIT).
- `cfg_done`  out  1  one-cycle pulse: the frame was committed to `con`.
- `cfg_err`  out  1  one-cycle pulse: checksum mismatch, frame dropped.
- `con`  out  CFG_W  live switch-box configuration (registered).

## Operation
- A byte is transferred on a rising edge where `cfg_valid && cfg_ready`. No other byte is consumed.
- Frame format: `SYNC`, then `NBYTES` data bytes, then one checksum byte.
  - Data byte k maps to shadow[8k+7:8k], so byte 0 lands in `con[7:0]`.
  - Checksum is the XOR of all `NBYTES` data bytes. The sync byte is excluded.
- FSM states:
  - IDLE: accepted bytes other than `SYNC` are silently discarded. On `SYNC`, clear the byte counter and the running XOR, then go to LOAD.
  - LOAD: each accepted byte is written to the shadow at index `cnt`, XORed into `xacc`, and `cnt` is incremented. When the accepted byte has `cnt == NBYTES-1`, go to CHECK. A `SYNC` value inside LOAD is ordinary data.
  - CHECK: the next accepted byte is compared against `xacc`. Match: set the commit flag. Mismatch: clear it. Either way, go to COMMIT.
  - COMMIT: takes one cycle, with `cfg_ready` = 0. On match, `con <= shadow` and `cfg_done <= 1`. On mismatch, `cfg_err <= 1` and `con` holds. Then go to IDLE.
- Byte counter `cnt` is 6 bits and counts 0..47. It never wraps inside a frame.
- `xacc` is 8 bits.
- `cfg_abort`:
  - In LOAD or CHECK: go to IDLE on the next edge. Shadow contents are don't-care, `con` holds, no pulse is generated, and any byte presented in the same cycle is not consumed (abort wins).
  - In COMMIT: ignored; the commit completes.
  - In IDLE: no effect.
- `cfg_ready` is registered-free decode: 1 in IDLE, LOAD and CHECK; 0 in COMMIT and during reset.
- `cfg_busy` = (state != IDLE).

## Timing
- Reset (asynchronous, `rst_n` low) forces:
  - state = IDLE, `cnt` = 0, `xacc` = 0;
  - `con` = 0, meaning all switch-box selects are off;
  - `cfg_done` = 0, `cfg_err` = 0, `cfg_busy` = 0, `cfg_ready` = 0.
- Shadow is not reset.
- `cfg_ready` rises in the first cycle after `rst_n` deasserts.
- Throughput: one byte per cycle through LOAD and CHECK. A minimum frame is `NBYTES`+2 accepted bytes plus one COMMIT cycle, i.e. 51 cycles.
- Latency: if the checksum byte is accepted at edge N, then:
  - `con` takes the new value and `cfg_done` (or `cfg_err`) is high starting at edge N+1, for exactly one cycle;
  - the next `SYNC` can be accepted at edge N+2.
- `cfg_valid` gaps of any length are allowed in every state; state, `cnt` and `xacc` hold.
- Reset asserted mid-frame: immediate return to reset values, and `con` is cleared to 0.
- `con` changes only at a COMMIT edge or on reset, and never partially.

## Test plan
- Reset check: hold `rst_n` = 0 with `cfg_valid` = 1 → `con` = 0, `cfg_ready` = 0, no pulses. Release reset → `cfg_ready` = 1 one cycle later.
- Good frame: `A5`, then byte0 = 0x21 (33), byte1 = 0x01, bytes 2..47 = 0x00, then checksum 0x20 → `con[7:0]` = 0x21, `con[15:8]` = 0x01, rest 0. `cfg_done` pulses once, exactly one cycle after the checksum edge. `cfg_ready` = 0 for that one cycle.
- Bad checksum: same frame with checksum 0x21 → `cfg_err` pulses, `cfg_done` = 0, `con` keeps its prior value bit-for-bit.
- Abort: send `A5` plus 20 data bytes, then assert `cfg_abort` together with `cfg_valid` → byte not consumed, `cfg_busy` = 0 next cycle, `con` unchanged. A following good frame commits correctly with `cnt` restarted at 0.
- Junk and stalls: bytes 0x00, 0xFF and 0x5A in IDLE are ignored (`cfg_busy` stays 0). A good frame then sent with random 0–3 cycle `cfg_valid` gaps, with 0xA5 as data byte 5, commits the expected pattern.
- Back-to-back: two good frames with no idle cycles between them (second `SYNC` presented during COMMIT) → the second `SYNC` is accepted one cycle late, and both `cfg_done` pulses occur with the final `con` equal to frame 2.
